core_mdu: RTL
=============

Name: core_mdu

Overview:
Iterative multiply/divide unit implementing the RV32M operations. It sits beside core_alu in the execute stage and is parametrised in operand width. Execution is multi-cycle with a start/busy/done handshake, so the pipeline stalls on busy_out. Divide-by-zero and signed overflow are resolved on a single-cycle fast path.

Parameters:
XLEN, 32, operand/result width; legal values are 8..64, even.
CNT_W, $clog2(XLEN)+1, width of the iteration counter; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset; asynchronous, active-low.
start_in  input  1  request; sampled only in IDLE.
func_in  input  3  operation, funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
opnum1_in  input  XLEN  rs1 operand; dividend or multiplicand.
opnum2_in  input  XLEN  rs2 operand; divisor or multiplier.
flush_in  input  1  abort; returns to IDLE at the next edge with no done pulse.
busy_out  output  1  high whenever state != IDLE.
done_out  output  1  one-cycle pulse; res_out is valid in that cycle.
res_out  output  XLEN  result; holds its last value until the next done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy_out=0, done_out=0, res_out=0, counter=0, internal registers=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE with start_in=1 at edge E0:
  - Latch func and operands.
  - Take operand magnitudes; signedness: MULH signed×signed; MULHSU signed rs1×unsigned rs2; DIV/REM signed; others unsigned.
  - Record the result-sign flag.
  - Go to CALC with counter=0, or to DONE on the fast path.
- Fast path (DIV/DIVU/REM/REMU only):
  - divisor==0: quotient = all ones; remainder = opnum1_in unchanged.
  - Signed op with dividend = 1<<(XLEN-1) and divisor = all ones: quotient = dividend, remainder = 0.
  - Result is written at E0; state=DONE; done_out high the cycle after E0.
- CALC, multiply: radix-2 shift-add over a 2*XLEN product register, one multiplier bit per edge.
- CALC, divide: restoring shift-subtract, one quotient bit per edge.
- CALC lasts exactly XLEN edges (E1..E_XLEN); then state=FIX.
- FIX (edge E_XLEN+1):
  - Apply sign correction: negate the product if the sign flag is set; quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Select the result: MUL = product[XLEN-1:0]; MULH/MULHSU/MULHU = product[2XLEN-1:XLEN]; DIV(U) = quotient; REM(U) = remainder.
  - Register the result into res_out; state=DONE.
- DONE: done_out=1 for exactly one cycle; next edge returns to IDLE.
- Normal latency: done_out asserted XLEN+2 cycles after the accept cycle; busy_out high for XLEN+2 cycles.
- start_in is ignored while busy_out=1, including in DONE. Back-to-back: the next request can be accepted in the cycle after done_out.
- Operands and func are captured only at accept; input changes during CALC have no effect.
- flush_in:
  - Highest priority after reset.
  - In CALC/FIX/DONE: next state IDLE, done_out=0, res_out unchanged.
  - In IDLE with start_in=1: the request is not accepted.
- rst_n low mid-operation: immediate return to reset values; no done pulse.
- Arithmetic is modulo 2^XLEN; no exceptions or flags.

Test Plan:
- XLEN=32, MUL 7 × 0xFFFFFFFD -> res 0xFFFFFFEB; done exactly 34 cycles after accept; busy high 34 cycles.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- Fast path: DIVU 0x10/0 -> 0xFFFFFFFF; REMU 0x10/0 -> 0x10; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; done the cycle after accept in each case.
- Abort and ignore:
  - Start DIV, assert flush_in at cycle 10 -> IDLE next cycle, no done, res_out unchanged.
  - start_in pulsed while busy -> ignored.
  - rst_n low mid-CALC -> all outputs 0 immediately.
- XLEN=8 instance: MUL 0x0F×0x11 -> 0xFF; DIV 0x80/0x03 (signed) -> 0xD6, REM -> 0xFE; latency 10 cycles.

Source files
------------

// File: rtl/core_mdu.sv
// core_mdu: iterative RV32M multiply/divide unit for the execute stage.
//
// Multiply is radix-2 shift-add over a 2*XLEN product register; divide is
// restoring shift-subtract. Both work on operand magnitudes and apply the
// sign correction in a single FIX cycle. Divide-by-zero and signed overflow
// bypass the iteration and finish the cycle after accept.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start_in   request, sampled only in IDLE
//   func_in    funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   opnum1_in  rs1: multiplicand / dividend
//   opnum2_in  rs2: multiplier / divisor
//   flush_in   abort to IDLE, no done pulse, res_out kept
//   busy_out   high whenever not IDLE
//   done_out   one-cycle pulse, res_out valid
//   res_out    result, held until the next done
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_in
// CALC  | one multiplier / quotient bit per edge, XLEN edges
// FIX   | sign correction and result select into res_out
// DONE  | done_out pulse, back to IDLE next edge

module core_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_in,
  input  logic [2:0]      func_in,
  input  logic [XLEN-1:0] opnum1_in,
  input  logic [XLEN-1:0] opnum2_in,
  input  logic            flush_in,
  output logic            busy_out,
  output logic            done_out,
  output logic [XLEN-1:0] res_out
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        func_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic [XLEN-1:0]   mag1_q;
  logic [XLEN-1:0]   mag2_q;
  logic [2*XLEN-1:0] prod_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   res_q;

  // Request decode
  logic            is_div_in;
  logic            sgn1_in;
  logic            sgn2_in;
  logic            neg1_in;
  logic            neg2_in;
  logic [XLEN-1:0] mag1_in;
  logic [XLEN-1:0] mag2_in;
  logic            div_zero_in;
  logic            div_ovf_in;
  logic            fast_in;
  logic [XLEN-1:0] fast_res_in;
  logic            accept;

  always_comb begin
    is_div_in = func_in[2];
    // rs1 signed for MULH, MULHSU, DIV, REM; rs2 signed for MULH, DIV, REM
    sgn1_in = (func_in == 3'd1) || (func_in == 3'd2) ||
              (func_in == 3'd4) || (func_in == 3'd6);
    sgn2_in = (func_in == 3'd1) || (func_in == 3'd4) || (func_in == 3'd6);
    neg1_in = sgn1_in & opnum1_in[XLEN-1];
    neg2_in = sgn2_in & opnum2_in[XLEN-1];
    mag1_in = neg1_in ? (~opnum1_in + 1'b1) : opnum1_in;
    mag2_in = neg2_in ? (~opnum2_in + 1'b1) : opnum2_in;

    div_zero_in = (opnum2_in == '0);
    div_ovf_in  = is_div_in && !func_in[0] &&
                  (opnum1_in == {1'b1, {(XLEN-1){1'b0}}}) &&
                  (opnum2_in == '1);
    fast_in = is_div_in && (div_zero_in || div_ovf_in);

    // func_in[1] selects remainder among the divide ops
    if (div_zero_in) begin
      fast_res_in = func_in[1] ? opnum1_in : '1;
    end else begin
      fast_res_in = func_in[1] ? '0 : opnum1_in;
    end

    accept = (state_q == S_IDLE) && start_in && !flush_in;
  end

  // Iteration step
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_part;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    // Multiply: upper half accumulates, lower half shifts the multiplier out
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mag1_q};
    mul_next = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]}
                         : {1'b0, prod_q[2*XLEN-1:1]};
    // Divide: upper half is the partial remainder, lower half shifts the
    // dividend out and the quotient bits in
    div_part = prod_q[2*XLEN-1:XLEN-1];
    div_diff = div_part - {1'b0, mag2_q};
    div_next = div_diff[XLEN] ? {prod_q[2*XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
  end

  // Sign correction and result select
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod_fix = neg_res_q ? (~prod_q + 1'b1) : prod_q;
    quo_fix  = neg_res_q ? (~prod_q[XLEN-1:0] + 1'b1) : prod_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? (~prod_q[2*XLEN-1:XLEN] + 1'b1)
                         : prod_q[2*XLEN-1:XLEN];
    if (func_q[2]) begin
      fix_res = func_q[1] ? rem_fix : quo_fix;
    end else begin
      fix_res = (func_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0]
                                      : prod_fix[2*XLEN-1:XLEN];
    end
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    busy_out = (state_q != S_IDLE);
    done_out = (state_q == S_DONE) && !flush_in;
    case (state_q)
      S_IDLE: if (accept) state_d = fast_in ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CNT_LAST) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_in) state_d = S_IDLE;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mag1_q    <= '0;
      mag2_q    <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
    end else if (!flush_in) begin
      if (accept) begin
        func_q    <= func_in;
        neg_res_q <= neg1_in ^ neg2_in;
        neg_rem_q <= neg1_in;
        mag1_q    <= mag1_in;
        mag2_q    <= mag2_in;
        cnt_q     <= '0;
        prod_q    <= is_div_in ? {{XLEN{1'b0}}, mag1_in} : {{XLEN{1'b0}}, mag2_in};
        if (fast_in) res_q <= fast_res_in;
      end else if (state_q == S_CALC) begin
        cnt_q  <= cnt_q + 1'b1;
        prod_q <= func_q[2] ? div_next : mul_next;
      end else if (state_q == S_FIX) begin
        res_q <= fix_res;
      end
    end
  end

  assign res_out = res_q;

endmodule
